// File: rtl/store_buffer.sv
// Posted-write buffer between the core data port and data memory: queues stores,
// coalesces repeat stores to the youngest word, and forwards queued data to loads.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    input  logic                     memread,
    output logic                     stall,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_adr,
    output logic [DW-1:0]            mem_wd,
    input  logic                     mem_ack,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-3:0] r_adr  [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_mem_we;
    logic          w_pop;
    logic          w_full;
    logic          w_coalesce;
    logic          w_push;
    logic [PW-1:0] w_young;
    logic [AW-3:0] w_word;
    logic          w_match;
    logic [DW-1:0] w_match_data;

    assign w_word   = dataadr[AW-1:2];
    assign w_young  = r_tail - PW'(1);
    assign w_mem_we = (r_count != '0);
    assign w_pop    = w_mem_we & mem_ack;
    assign w_full   = (r_count == CW'(DEPTH));

    // The youngest entry may only absorb a store if it is not leaving this cycle.
    assign w_coalesce = memwrite && w_mem_we && (r_adr[w_young] == w_word)
                        && !(w_pop && (w_young == r_head));
    assign w_push     = memwrite && !w_coalesce && (!w_full || w_pop);
    assign stall      = memwrite && w_full && !w_coalesce && !w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_adr[i]  <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_coalesce) begin
                r_data[w_young] <= writedata;
            end
            if (w_push) begin
                r_adr[r_tail]  <= w_word;
                r_data[r_tail] <= writedata;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        w_match      = 1'b0;
        w_match_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < r_count) && (r_adr[r_head + PW'(k)] == w_word)) begin
                w_match      = 1'b1;
                w_match_data = r_data[r_head + PW'(k)];
            end
        end
    end

    assign fwd_hit  = memread & w_match;
    assign fwd_data = fwd_hit ? w_match_data : '0;

    assign mem_we  = w_mem_we;
    assign mem_adr = {r_adr[r_head], 2'b00};
    assign mem_wd  = r_data[r_head];
    assign empty   = (r_count == '0);
    assign count   = r_count;

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MIPS core's data-memory port (`memwrite`, `dataadr`, `writedata`) and the data memory. Core stores are queued in a small FIFO and drained to memory one per acknowledged cycle. Loads that hit a queued address are forwarded from the buffer. The core stalls only when the buffer is full and cannot accept the store.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `memwrite`  in  1  core store request this cycle.
- `dataadr`  in  AW  core byte address; bits [1:0] are ignored (word access).
- `writedata`  in  DW  core store data.
- `memread`  in  1  core load request this cycle.
- `stall`  out  1  store not accepted; core holds its request.
- `fwd_hit`  out  1  load address matches a queued entry.
- `fwd_data`  out  DW  data from the youngest matching entry.
- `mem_we`  out  1  head entry valid and presented to memory.
- `mem_adr`  out  AW  head address.
- `mem_wd`  out  DW  head data.
- `mem_ack`  in  1  memory accepted the head this cycle.
- `empty`  out  1  no valid entries.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.

## Operation
- Storage: circular array of {adr[AW-1:2], data}, with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Pop: `pop = mem_we & mem_ack`. The head entry is retired and the head pointer advances.
- Coalesce: occurs when `memwrite` is high, count > 0, the word address equals the youngest entry (tail-1), and that entry is not being popped this cycle (it is not the head while `pop` is high). The youngest entry's data is overwritten and count is unchanged. Coalescing is allowed even when the buffer is full.
- Push: `memwrite` without coalescing. The store is written at the tail, the tail pointer advances and count increments. The push is accepted only if count < DEPTH, or if count == DEPTH and `pop` is high in the same cycle. In the full-with-pop case count stays at DEPTH.
- `stall` is combinational: high when `memwrite` is high, count == DEPTH, there is no coalesce and `pop` is low. While stalled, the store is not written and the core repeats it.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Forwarding (combinational):
  - Compare `dataadr[AW-1:2]` against every valid entry.
  - Priority goes to the youngest entry.
  - `fwd_hit = memread & match`. `fwd_data` is the matching entry's data, or 0 when there is no hit.
  - Compares use registered contents only. A store in the same cycle is not bypassed.
  - An entry popped this cycle still forwards this cycle.
- Memory side: `mem_we = (count != 0)`. `mem_adr = {head.adr, 2'b00}`. `mem_wd = head.data`. `mem_ack` while `mem_we` is low is ignored.
- Ordering: memory sees stores in program order, except that coalesced stores to the same word collapse into one write.

## Timing
- Reset (asynchronous, immediate):
  - count = 0, pointers = 0, entries cleared to 0.
  - Outputs: `mem_we` = 0, `mem_adr` = 0, `mem_wd` = 0, `empty` = 1, `stall` = 0, `fwd_hit` = 0, `fwd_data` = 0.
  - Reset mid-drain discards all queued stores and does not complete them.
- Latency, store to memory: a store accepted at edge N has `mem_we` high after edge N if the buffer was empty. Minimum latency is 1 cycle.
- Throughput: one pop per cycle when `mem_ack` is held high.
- Forwarding becomes visible the cycle after the accepting edge.
- `empty` and `count` are registered-state derived and update at the edge.
- `stall` depends combinationally on `mem_ack`. Memory must not make `mem_ack` depend on `stall`.

## Test plan
- Reset, then a store to 80 with data 3 and `mem_ack` held 1 -> next cycle `mem_we`=1, `mem_adr`=80, `mem_wd`=3; one cycle later `empty`=1.
- With `mem_ack`=0, stores to 0, 4, 8, 12, then 16 -> `count`=4, and `stall`=1 on the store to 16. Raise `mem_ack` -> 16 is accepted that cycle and drains order is 0, 4, 8, 12, 16.
- Stores to 84 with data 5, then to 84 with data 7, with `mem_ack`=0 -> `count`=1. Release -> exactly one memory write, `mem_adr`=84, `mem_wd`=7.
- Stores to 80 with data 1, then 84 with data 2, then 80 with data 9 (not coalesced, since 80 is not the youngest), then a load from 80 -> `fwd_hit`=1, `fwd_data`=9. A load from 88 -> `fwd_hit`=0.
- Full buffer with simultaneous `mem_ack` and a store -> no stall, `count` stays 4, and the new entry drains last.
- Assert `reset` while `count`=3 -> `mem_we`=0 and `empty`=1 immediately, and no further memory writes occur.
